gnn_in_loader: RTL and testbench

GNN_IN_LOADER -- requirements
Module: gnn_in_loader

---
 rtl/gnn_in_loader.sv | 88 ++++++++
 tb/tb_gnn_in_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_in_loader.sv
// Frame loader for the GNN array: deserialises a 40-word stream of signed features and weights
// into parallel registers, then fires a one-cycle in_ready pulse and optionally waits for gnn_done.
module gnn_in_loader #(
  parameter int WAIT_DONE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic signed [4:0] s_data,
  input  logic              s_last,
  output logic signed [4:0] x0_node0, x1_node0, x2_node0, x3_node0,
  output logic signed [4:0] x0_node1, x1_node1, x2_node1, x3_node1,
  output logic signed [4:0] x0_node2, x1_node2, x2_node2, x3_node2,
  output logic signed [4:0] x0_node3, x1_node3, x2_node3, x3_node3,
  output logic signed [4:0] w04, w14, w24, w34, w05, w15, w25, w35,
  output logic signed [4:0] w06, w16, w26, w36, w07, w17, w27, w37,
  output logic signed [4:0] w48, w58, w68, w78, w49, w59, w69, w79,
  output logic              in_ready,
  input  logic              gnn_done,
  input  logic              err_clr,
  output logic              frame_err,
  output logic [5:0]        word_cnt
);

  typedef enum logic [1:0] {S_INIT, S_LOAD, S_FIRE, S_WAIT} state_t;

  localparam logic [5:0] LAST_IDX = 6'd39;

  state_t            state;
  logic signed [4:0] regs [40];

  assign s_ready = (state == S_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      word_cnt  <= '0;
      in_ready  <= 1'b0;
      frame_err <= 1'b0;
      // NOTE: the register file is reset explicitly because the outputs must read 0 out of reset;
      // a plain storage array without that requirement would be left unreset.
      for (int i = 0; i < 40; i++) regs[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so later writes in this block
      // (a new framing error) override earlier ones (err_clr) within the same edge.
      in_ready <= 1'b0;
      if (err_clr) frame_err <= 1'b0;
      case (state)
        S_INIT: state <= S_LOAD;
        S_LOAD: begin
          if (s_valid) begin
            regs[word_cnt] <= s_data;
            if (word_cnt == LAST_IDX) begin
              word_cnt <= '0;
              state    <= S_FIRE;
              in_ready <= 1'b1;
              if (!s_last) frame_err <= 1'b1;
            end else if (s_last) begin
              // Short frame: restart from index 0; already-written registers keep their values.
              word_cnt  <= '0;
              frame_err <= 1'b1;
            end else begin
              word_cnt <= word_cnt + 6'd1;
            end
          end
        end
        S_FIRE: state <= (WAIT_DONE != 0) ? S_WAIT : S_LOAD;
        S_WAIT: if (gnn_done) state <= S_LOAD;
        default: state <= S_INIT;
      endcase
    end
  end

  assign x0_node0 = regs[0];  assign x1_node0 = regs[1];  assign x2_node0 = regs[2];  assign x3_node0 = regs[3];
  assign x0_node1 = regs[4];  assign x1_node1 = regs[5];  assign x2_node1 = regs[6];  assign x3_node1 = regs[7];
  assign x0_node2 = regs[8];  assign x1_node2 = regs[9];  assign x2_node2 = regs[10]; assign x3_node2 = regs[11];
  assign x0_node3 = regs[12]; assign x1_node3 = regs[13]; assign x2_node3 = regs[14]; assign x3_node3 = regs[15];

  assign w04 = regs[16]; assign w14 = regs[17]; assign w24 = regs[18]; assign w34 = regs[19];
  assign w05 = regs[20]; assign w15 = regs[21]; assign w25 = regs[22]; assign w35 = regs[23];
  assign w06 = regs[24]; assign w16 = regs[25]; assign w26 = regs[26]; assign w36 = regs[27];
  assign w07 = regs[28]; assign w17 = regs[29]; assign w27 = regs[30]; assign w37 = regs[31];

  assign w48 = regs[32]; assign w58 = regs[33]; assign w68 = regs[34]; assign w78 = regs[35];
  assign w49 = regs[36]; assign w59 = regs[37]; assign w69 = regs[38]; assign w79 = regs[39];

endmodule

// File: tb/tb_gnn_in_loader.sv
// Directed bench for gnn_in_loader: instance a holds frames until gnn_done, instance b reloads
// straight after fire; expected register contents come from a per-word model of the stream.
module tb_gnn_in_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              s_valid_a = 0, s_last_a = 0, gnn_done_a = 0, err_clr_a = 0;
  logic signed [4:0] s_data_a = '0;
  logic              s_ready_a, in_ready_a, frame_err_a;
  logic [5:0]        word_cnt_a;
  logic signed [4:0] ov_a [40];
  logic signed [4:0] exp_a [40];

  logic              s_valid_b = 0, s_last_b = 0, gnn_done_b = 0, err_clr_b = 0;
  logic signed [4:0] s_data_b = '0;
  logic              s_ready_b, in_ready_b, frame_err_b;
  logic [5:0]        word_cnt_b;
  logic signed [4:0] ov_b [40];
  logic signed [4:0] exp_b [40];

  int n_pass = 0, n_total = 0;
  int cycle = 0, fires_a = 0, fires_b = 0;
  int fire_cyc_b [4];

  gnn_in_loader #(.WAIT_DONE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a), .s_last(s_last_a),
    .x0_node0(ov_a[0]),  .x1_node0(ov_a[1]),  .x2_node0(ov_a[2]),  .x3_node0(ov_a[3]),
    .x0_node1(ov_a[4]),  .x1_node1(ov_a[5]),  .x2_node1(ov_a[6]),  .x3_node1(ov_a[7]),
    .x0_node2(ov_a[8]),  .x1_node2(ov_a[9]),  .x2_node2(ov_a[10]), .x3_node2(ov_a[11]),
    .x0_node3(ov_a[12]), .x1_node3(ov_a[13]), .x2_node3(ov_a[14]), .x3_node3(ov_a[15]),
    .w04(ov_a[16]), .w14(ov_a[17]), .w24(ov_a[18]), .w34(ov_a[19]),
    .w05(ov_a[20]), .w15(ov_a[21]), .w25(ov_a[22]), .w35(ov_a[23]),
    .w06(ov_a[24]), .w16(ov_a[25]), .w26(ov_a[26]), .w36(ov_a[27]),
    .w07(ov_a[28]), .w17(ov_a[29]), .w27(ov_a[30]), .w37(ov_a[31]),
    .w48(ov_a[32]), .w58(ov_a[33]), .w68(ov_a[34]), .w78(ov_a[35]),
    .w49(ov_a[36]), .w59(ov_a[37]), .w69(ov_a[38]), .w79(ov_a[39]),
    .in_ready(in_ready_a), .gnn_done(gnn_done_a), .err_clr(err_clr_a),
    .frame_err(frame_err_a), .word_cnt(word_cnt_a)
  );

  gnn_in_loader #(.WAIT_DONE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b), .s_last(s_last_b),
    .x0_node0(ov_b[0]),  .x1_node0(ov_b[1]),  .x2_node0(ov_b[2]),  .x3_node0(ov_b[3]),
    .x0_node1(ov_b[4]),  .x1_node1(ov_b[5]),  .x2_node1(ov_b[6]),  .x3_node1(ov_b[7]),
    .x0_node2(ov_b[8]),  .x1_node2(ov_b[9]),  .x2_node2(ov_b[10]), .x3_node2(ov_b[11]),
    .x0_node3(ov_b[12]), .x1_node3(ov_b[13]), .x2_node3(ov_b[14]), .x3_node3(ov_b[15]),
    .w04(ov_b[16]), .w14(ov_b[17]), .w24(ov_b[18]), .w34(ov_b[19]),
    .w05(ov_b[20]), .w15(ov_b[21]), .w25(ov_b[22]), .w35(ov_b[23]),
    .w06(ov_b[24]), .w16(ov_b[25]), .w26(ov_b[26]), .w36(ov_b[27]),
    .w07(ov_b[28]), .w17(ov_b[29]), .w27(ov_b[30]), .w37(ov_b[31]),
    .w48(ov_b[32]), .w58(ov_b[33]), .w68(ov_b[34]), .w78(ov_b[35]),
    .w49(ov_b[36]), .w59(ov_b[37]), .w69(ov_b[38]), .w79(ov_b[39]),
    .in_ready(in_ready_b), .gnn_done(gnn_done_b), .err_clr(err_clr_b),
    .frame_err(frame_err_b), .word_cnt(word_cnt_b)
  );

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (in_ready_a) fires_a <= fires_a + 1;
    if (in_ready_b) begin
      if (fires_b < 4) fire_cyc_b[fires_b] <= cycle;
      fires_b <= fires_b + 1;
    end
  end

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives words lo..hi into instance a; s_last rides on index last_at (-1 = never).
  task automatic send_range(input int lo, input int hi, input int mul, input int add,
                            input bit gapped, input int last_at);
    for (int i = lo; i <= hi; i++) begin
      logic signed [4:0] d;
      bit acc;
      int n;
      d = 5'(i * mul + add);
      s_valid_a = 1'b1;
      s_data_a  = d;
      s_last_a  = (i == last_at);
      acc = 1'b0;
      n = 0;
      while (!acc) begin
        acc = s_ready_a;
        tick();
        n++;
        if (!acc && n > 50) begin
          check($sformatf("handshake_timeout_idx%0d", i), 0, 1);
          s_valid_a = 1'b0;
          s_last_a  = 1'b0;
          return;
        end
      end
      exp_a[i] = d;
      s_valid_a = 1'b0;
      s_last_a  = 1'b0;
      if (gapped && i != hi) tick();
    end
  endtask

  task automatic check_regs_a(input string tag);
    for (int k = 0; k < 40; k++) check($sformatf("%s_reg%0d", tag, k), ov_a[k], exp_a[k]);
  endtask

  // Called right after the 40th word is accepted; holds gnn_done high during FIRE to show it is ignored.
  task automatic frame_fired(input string tag, input bit exp_err);
    check({tag, "_in_ready_on"}, in_ready_a, 1);
    gnn_done_a = 1'b1;
    tick();
    gnn_done_a = 1'b0;
    check({tag, "_in_ready_off"}, in_ready_a, 0);
    check({tag, "_wait_s_ready"}, s_ready_a, 0);
    check({tag, "_frame_err"}, frame_err_a, exp_err);
    check({tag, "_word_cnt"}, word_cnt_a, 0);
    check_regs_a(tag);
    tick();
    check({tag, "_still_wait"}, s_ready_a, 0);
    gnn_done_a = 1'b1;
    tick();
    gnn_done_a = 1'b0;
    check({tag, "_back_to_load"}, s_ready_a, 1);
  endtask

  typedef struct {
    int mul;
    int add;
    bit gapped;
    int last_at;
    bit exp_err;
  } frame_vec_t;

  frame_vec_t vecs [4];

  initial begin
    logic [4:0] bits;
    int nonzero;
    int idx, acc_n, cyc;

    vecs[0] = '{mul: 3,  add: 5,  gapped: 1'b0, last_at: 39, exp_err: 1'b0};
    vecs[1] = '{mul: 7,  add: 1,  gapped: 1'b1, last_at: 39, exp_err: 1'b0};
    vecs[2] = '{mul: 11, add: 30, gapped: 1'b1, last_at: 39, exp_err: 1'b0};
    vecs[3] = '{mul: 5,  add: 2,  gapped: 1'b0, last_at: -1, exp_err: 1'b1};
    for (int k = 0; k < 40; k++) begin
      exp_a[k] = '0;
      exp_b[k] = '0;
    end

    // Reset state.
    #12;
    check("rst_s_ready", s_ready_a, 0);
    check("rst_in_ready", in_ready_a, 0);
    check("rst_frame_err", frame_err_a, 0);
    check("rst_word_cnt", word_cnt_a, 0);
    check_regs_a("rst");
    rst_n = 1'b1;
    tick();
    check("init_to_load", s_ready_a, 1);

    // Index-valued frame.
    send_range(0, 39, 1, 0, 1'b0, 39);
    check("idx_in_ready", in_ready_a, 1);
    check("idx_frame_err", frame_err_a, 0);
    check("idx_x0_node0", ov_a[0], 0);
    check("idx_x3_node3", ov_a[15], 15);
    bits = ov_a[16];
    check("idx_w04_bits", bits, 16);
    check("idx_w79", ov_a[39], 7);
    check_regs_a("idx");

    // Stalled upstream while waiting for gnn_done.
    s_valid_a = 1'b1;
    s_data_a  = 5'b10000;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("hold%0d_s_ready", c), s_ready_a, 0);
      check($sformatf("hold%0d_in_ready", c), in_ready_a, 0);
      check($sformatf("hold%0d_x0_node0", c), ov_a[0], 0);
      check($sformatf("hold%0d_w79", c), ov_a[39], 7);
    end
    gnn_done_a = 1'b1;
    tick();
    gnn_done_a = 1'b0;
    check("release_s_ready", s_ready_a, 1);
    tick();
    s_valid_a = 1'b0;
    exp_a[0] = -5'sd16;
    check("release_x0_node0", ov_a[0], -16);
    check("release_word_cnt", word_cnt_a, 1);
    send_range(1, 39, 1, 16, 1'b0, 39);
    frame_fired("held", 1'b0);

    // Table of whole frames.
    foreach (vecs[v]) begin
      send_range(0, 39, vecs[v].mul, vecs[v].add, vecs[v].gapped, vecs[v].last_at);
      frame_fired($sformatf("vec%0d", v), vecs[v].exp_err);
    end
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    check("err_clr_after_missing_last", frame_err_a, 0);

    // Early s_last at idx 5.
    send_range(0, 5, 13, 3, 1'b0, 5);
    check("early_frame_err", frame_err_a, 1);
    check("early_word_cnt", word_cnt_a, 0);
    check("early_no_fire", in_ready_a, 0);
    check("early_s_ready", s_ready_a, 1);
    send_range(0, 39, 2, 9, 1'b0, 39);
    frame_fired("after_early", 1'b1);

    // New error in the same cycle as err_clr keeps the flag set.
    err_clr_a = 1'b1;
    send_range(0, 0, 1, 4, 1'b0, 0);
    err_clr_a = 1'b0;
    check("err_wins_over_clr", frame_err_a, 1);
    check("err_wins_word_cnt", word_cnt_a, 0);
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    check("err_clr_pulse", frame_err_a, 0);

    // Asynchronous reset mid-frame at idx 20.
    send_range(0, 19, 3, 1, 1'b0, -1);
    check("mid_word_cnt", word_cnt_a, 20);
    #3;
    rst_n = 1'b0;
    #1;
    nonzero = 0;
    for (int k = 0; k < 40; k++) if (ov_a[k] !== 5'sd0) nonzero++;
    check("async_rst_regs_cleared", nonzero, 0);
    check("async_rst_word_cnt", word_cnt_a, 0);
    check("async_rst_s_ready", s_ready_a, 0);
    check("async_rst_frame_err", frame_err_a, 0);
    for (int k = 0; k < 40; k++) exp_a[k] = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_s_ready", s_ready_a, 1);
    send_range(0, 39, 9, 7, 1'b0, 39);
    frame_fired("post_rst", 1'b0);
    check("fires_a_total", fires_a, 8);

    // WAIT_DONE=0: two back-to-back frames, gnn_done held high throughout.
    gnn_done_b = 1'b1;
    s_valid_b  = 1'b1;
    idx = 0;
    acc_n = 0;
    cyc = 0;
    while (acc_n < 80 && cyc < 300) begin
      logic signed [4:0] d;
      bit acc;
      d = 5'(idx * 9 + 4 + (acc_n / 40) * 7);
      s_data_b = d;
      s_last_b = (idx == 39);
      acc = s_ready_b;
      tick();
      cyc++;
      if (acc) begin
        exp_b[idx] = d;
        idx = (idx == 39) ? 0 : idx + 1;
        acc_n++;
      end
    end
    s_valid_b = 1'b0;
    s_last_b  = 1'b0;
    check("b2b_words_accepted", acc_n, 80);
    check("b2b_second_fire", in_ready_b, 1);
    tick();
    check("b2b_fire_count", fires_b, 2);
    check("b2b_fire_period", fire_cyc_b[1] - fire_cyc_b[0], 41);
    check("b2b_frame_err", frame_err_b, 0);
    check("b2b_back_to_load", s_ready_b, 1);
    for (int k = 0; k < 40; k++) check($sformatf("b2b_reg%0d", k), ov_b[k], exp_b[k]);
    gnn_done_b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
